// File: rtl/ai_signal_recognizer_mc.sv
// ai_signal_recognizer_mc: multi-channel waveform classifier with per-channel
// majority vote over the last HIST_DEPTH decisions.
// Optional build macro AI_RECOG_HYST_EN adds per-channel type hysteresis.
module ai_signal_recognizer_mc #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FEAT_W     = 16,
  parameter int unsigned HIST_DEPTH = 8,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ai_enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [FEAT_W-1:0] in_zcr,
  input  logic [FEAT_W-1:0] in_crest,
  input  logic [FEAT_W-1:0] in_thd,
  input  logic [FEAT_W-1:0] thd_noise_th,
  input  logic [FEAT_W-1:0] thd_sine_th,
  input  logic [FEAT_W-1:0] crest_sq_th,
  input  logic [FEAT_W-1:0] crest_tri_th,
  input  logic [NUM_CH-1:0] ch_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [2:0]        out_type,
  output logic [2:0]        out_raw_type,
  output logic [7:0]        out_confidence,
  output logic              out_warm
);

  localparam int unsigned AW     = $clog2(HIST_DEPTH);
  localparam int unsigned FW     = AW + 1;
  localparam int unsigned FW1    = FW + 1;
  localparam int unsigned PW     = FW + 9;
  localparam int unsigned WEIGHT = 256 / HIST_DEPTH;

  logic            s1_valid;
  logic [CH_W-1:0] s1_ch;
  logic [2:0]      s1_type;

  logic [2:0]    hist [NUM_CH][HIST_DEPTH];
  logic [AW-1:0] wptr [NUM_CH];
  logic [FW-1:0] fill [NUM_CH];
`ifdef AI_RECOG_HYST_EN
  logic [2:0]    rep_type [NUM_CH];
  logic [2:0]    rep_sel;
`endif

  logic            advance;
  logic            in_fire;
  logic            s2_fire;
  logic            ch_ok;
  logic [CH_W-1:0] s1_idx;
  logic [2:0]      cls_c;

  logic [2:0]    hist_new [HIST_DEPTH];
  logic [FW-1:0] fill_new;
  logic [FW-1:0] cnt [8];
  logic [FW-1:0] age [8];
  logic [AW-1:0] ent_age;
  logic [2:0]    best_type;
  logic [2:0]    vote_type;
  logic [FW-1:0] vote_cnt;
  logic [PW-1:0] prod;
  logic [7:0]    conf_c;

  assign advance  = !out_valid || out_ready;
  assign in_ready = ai_enable && !rst && (!s1_valid || advance);
  assign in_fire  = in_valid && in_ready;
  assign s2_fire  = s1_valid && advance;
  assign ch_ok    = 32'(s1_ch) < NUM_CH;
  assign s1_idx   = ch_ok ? s1_ch : '0;

  // Priority decision tree on the incoming feature vector
  always_comb begin
    cls_c = 3'd4;
    if (in_thd >= thd_noise_th)       cls_c = 3'd5;
    else if (in_crest < crest_sq_th)  cls_c = 3'd2;
    else if (in_thd < thd_sine_th)    cls_c = 3'd1;
    else if (in_crest >= crest_tri_th) cls_c = 3'd3;
  end

  // Vote over the channel history with the S2 write already applied
  always_comb begin
    fill_new = (fill[s1_idx] == FW'(HIST_DEPTH)) ? fill[s1_idx] : fill[s1_idx] + 1'b1;
    ent_age  = '0;
    for (int k = 0; k < 8; k++) begin
      cnt[k] = '0;
      age[k] = FW'(HIST_DEPTH);
    end
    for (int i = 0; i < HIST_DEPTH; i++) begin
      hist_new[i] = (wptr[s1_idx] == AW'(i)) ? s1_type : hist[s1_idx][i];
      if (FW'(i) < fill_new) begin
        // age 0 is the entry being written now
        ent_age = wptr[s1_idx] - AW'(i);
        cnt[hist_new[i]] = cnt[hist_new[i]] + 1'b1;
        if ({1'b0, ent_age} < age[hist_new[i]]) age[hist_new[i]] = {1'b0, ent_age};
      end
    end
    best_type = 3'd0;
    for (int k = 1; k < 6; k++) begin
      if ((cnt[k] > cnt[best_type]) ||
          ((cnt[k] != '0) && (cnt[k] == cnt[best_type]) && (age[k] < age[best_type])))
        best_type = 3'(k);
    end
`ifdef AI_RECOG_HYST_EN
    rep_sel = rep_type[s1_idx];
    if ((rep_sel == 3'd0) || ({1'b0, cnt[best_type]} >= ({1'b0, cnt[rep_sel]} + FW1'(2))))
      vote_type = best_type;
    else
      vote_type = rep_sel;
`else
    vote_type = best_type;
`endif
    vote_cnt = cnt[vote_type];
    prod     = PW'(vote_cnt) * PW'(WEIGHT);
    conf_c   = (prod > PW'(255)) ? 8'hFF : prod[7:0];
  end

  // Two-stage pipeline: S1 classify, S2 vote and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1_ch          <= '0;
      s1_type        <= '0;
      out_valid      <= 1'b0;
      out_ch         <= '0;
      out_type       <= '0;
      out_raw_type   <= '0;
      out_confidence <= '0;
      out_warm       <= 1'b0;
    end else begin
      // S1 may fill while the output is stalled as long as it is empty
      if (advance || !s1_valid) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_ch   <= in_ch;
          s1_type <= cls_c;
        end
      end
      if (advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_ch       <= s1_ch;
          out_raw_type <= s1_type;
          if (ch_ok) begin
            out_type       <= vote_type;
            out_confidence <= conf_c;
            out_warm       <= fill_new < FW'(HIST_DEPTH);
          end else begin
            out_type       <= 3'd0;
            out_confidence <= 8'd0;
            out_warm       <= 1'b1;
          end
        end
      end
    end
  end

  // Per-channel history storage; clears override a same-cycle S2 update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr[c] <= '0;
        fill[c] <= '0;
`ifdef AI_RECOG_HYST_EN
        rep_type[c] <= '0;
`endif
        for (int i = 0; i < HIST_DEPTH; i++) hist[c][i] <= '0;
      end
    end else begin
      if (s2_fire && ch_ok) begin
        hist[s1_idx][wptr[s1_idx]] <= s1_type;
        wptr[s1_idx]               <= wptr[s1_idx] + 1'b1;
        fill[s1_idx]               <= fill_new;
`ifdef AI_RECOG_HYST_EN
        rep_type[s1_idx]           <= vote_type;
`endif
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (!ai_enable || ch_clear[c]) begin
          wptr[c] <= '0;
          fill[c] <= '0;
`ifdef AI_RECOG_HYST_EN
          rep_type[c] <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_ai_signal_recognizer_mc.sv
// Testbench for ai_signal_recognizer_mc: queue-based reference model plus
// directed scenarios with hand-computed expectations.
module tb_ai_signal_recognizer_mc;

  localparam int unsigned NUM_CH     = 5;
  localparam int unsigned FEAT_W     = 16;
  localparam int unsigned HIST_DEPTH = 8;
  localparam int unsigned CH_W       = 3;

  logic              clk;
  logic              rst;
  logic              ai_enable;
  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic [FEAT_W-1:0] in_zcr;
  logic [FEAT_W-1:0] in_crest;
  logic [FEAT_W-1:0] in_thd;
  logic [FEAT_W-1:0] thd_noise_th;
  logic [FEAT_W-1:0] thd_sine_th;
  logic [FEAT_W-1:0] crest_sq_th;
  logic [FEAT_W-1:0] crest_tri_th;
  logic [NUM_CH-1:0] ch_clear;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [2:0]        out_type;
  logic [2:0]        out_raw_type;
  logic [7:0]        out_confidence;
  logic              out_warm;

  ai_signal_recognizer_mc #(
    .NUM_CH(NUM_CH), .FEAT_W(FEAT_W), .HIST_DEPTH(HIST_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .ai_enable(ai_enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_zcr(in_zcr), .in_crest(in_crest), .in_thd(in_thd),
    .thd_noise_th(thd_noise_th), .thd_sine_th(thd_sine_th),
    .crest_sq_th(crest_sq_th), .crest_tri_th(crest_tri_th),
    .ch_clear(ch_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_type(out_type), .out_raw_type(out_raw_type),
    .out_confidence(out_confidence), .out_warm(out_warm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int typ;
    int raw;
    int conf;
    int warm;
  } exp_t;

  exp_t expq[$];
  int   hq[NUM_CH][$];
  int   rep[NUM_CH];
  int   n_checks = 0;
  int   n_err    = 0;
  int   last_type, last_conf, last_warm, last_raw, last_ch;
  bit   stalled = 1'b0;
  int   prev_pack;

  // vectors by class: sine, square, triangle, sawtooth, noise
  int vcrest[5] = '{32'h16A0, 32'h1000, 32'h1A00, 32'h1400, 32'h1000};
  int vthd[5]   = '{32'h0100, 32'h0100, 32'h0800, 32'h0800, 32'h5000};

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int classify(input int crest, input int thd);
    if (thd >= int'(thd_noise_th)) return 5;
    if (crest < int'(crest_sq_th)) return 2;
    if (thd < int'(thd_sine_th)) return 1;
    if (crest >= int'(crest_tri_th)) return 3;
    return 4;
  endfunction

  // Reference: keep the last HIST_DEPTH classes per channel, newest at the back
  function automatic void model_accept(input int ch, input int cls);
    exp_t e;
    int   cnt[6];
    int   maxc, best, c, n;
    bit   found;
    e.ch  = ch;
    e.raw = cls;
    if (ch >= int'(NUM_CH)) begin
      e.typ = 0; e.conf = 0; e.warm = 1;
    end else begin
      hq[ch].push_back(cls);
      if (hq[ch].size() > int'(HIST_DEPTH)) void'(hq[ch].pop_front());
      n = hq[ch].size();
      for (int k = 0; k < 6; k++) cnt[k] = 0;
      for (int i = 0; i < n; i++) cnt[hq[ch][i]]++;
      maxc = 0;
      for (int k = 1; k < 6; k++) if (cnt[k] > maxc) maxc = cnt[k];
      best = 0;
      found = 1'b0;
      for (int i = n - 1; i >= 0; i--) begin
        if (!found && cnt[hq[ch][i]] == maxc) begin
          best  = hq[ch][i];
          found = 1'b1;
        end
      end
`ifdef AI_RECOG_HYST_EN
      if (rep[ch] == 0 || cnt[best] >= cnt[rep[ch]] + 2) rep[ch] = best;
      best = rep[ch];
`endif
      c      = cnt[best];
      e.typ  = best;
      e.conf = (c * 256 / int'(HIST_DEPTH) > 255) ? 255 : c * 256 / int'(HIST_DEPTH);
      e.warm = (n < int'(HIST_DEPTH)) ? 1 : 0;
    end
    expq.push_back(e);
  endfunction

  // Compare process: scoreboard on output transfers, stall stability, model update
  always @(negedge clk) begin
    exp_t e;
    int   cur;
    if (rst) begin
      expq.delete();
      for (int c = 0; c < int'(NUM_CH); c++) begin
        hq[c].delete();
        rep[c] = 0;
      end
      stalled = 1'b0;
    end else begin
      cur = int'({out_valid, out_ch, out_type, out_raw_type, out_confidence, out_warm});
      if (stalled) check("stall_hold", cur, prev_pack);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          e = expq.pop_front();
          check("out_ch", int'(out_ch), e.ch);
          check("out_type", int'(out_type), e.typ);
          check("out_raw_type", int'(out_raw_type), e.raw);
          check("out_confidence", int'(out_confidence), e.conf);
          check("out_warm", int'(out_warm), e.warm);
        end
        last_ch   = int'(out_ch);
        last_type = int'(out_type);
        last_raw  = int'(out_raw_type);
        last_conf = int'(out_confidence);
        last_warm = int'(out_warm);
      end
      stalled   = out_valid && !out_ready;
      prev_pack = cur;
      for (int k = 0; k < int'(NUM_CH); k++) begin
        if (!ai_enable || ch_clear[k]) begin
          hq[k].delete();
          rep[k] = 0;
        end
      end
      if (in_valid && in_ready) model_accept(int'(in_ch), classify(int'(in_crest), int'(in_thd)));
    end
  end

  task automatic drive(input int ch, input int crest, input int thd);
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    in_crest = FEAT_W'(crest);
    in_thd   = FEAT_W'(thd);
    in_zcr   = FEAT_W'(crest ^ thd);
  endtask

  task automatic wait_ready();
    int  t  = 0;
    bit  ok = 1'b0;
    while (!ok && t < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      t++;
    end
    if (!ok) check("in_ready_timeout", 0, 1);
  endtask

  // Single vector into an idle pipeline; checks the two-cycle latency
  task automatic send(input int ch, input int crest, input int thd);
    @(posedge clk); #1;
    drive(ch, crest, thd);
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_n1", int'(out_valid), 0);
    @(negedge clk);
    check("latency_n2", int'(out_valid), 1);
    @(posedge clk); #1;
  endtask

  task automatic send_cls(input int ch, input int cls);
    send(ch, vcrest[cls-1], vthd[cls-1]);
  endtask

  // Continuous stream of n vectors cycling through the classes
  task automatic stream(input int ch, input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      drive(ch, vcrest[j % 5], vthd[j % 5]);
      wait_ready();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain_check();
    repeat (5) @(posedge clk);
    #1;
    check("drain_empty", expq.size(), 0);
  endtask

  initial begin
    rst = 1'b1; ai_enable = 1'b1; in_valid = 1'b0; in_ch = '0;
    in_zcr = '0; in_crest = '0; in_thd = '0; ch_clear = '0; out_ready = 1'b1;
    thd_noise_th = 16'h4000; thd_sine_th = 16'h0400;
    crest_sq_th  = 16'h1200; crest_tri_th = 16'h1800;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_outputs", int'({out_ch, out_type, out_raw_type, out_confidence, out_warm}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);

    // sine channel: confidence ramps in steps of 32, warm drops on the 8th
    for (int i = 0; i < 8; i++) begin
      send_cls(2, 1);
      check("sine_type", last_type, 1);
      check("sine_conf", last_conf, (i < 7) ? 32 * (i + 1) : 255);
      check("sine_warm", last_warm, (i < 7) ? 1 : 0);
    end

    // threshold boundaries on ch4
    send(4, 32'h1000, 32'h4000); check("bnd_noise_eq", last_raw, 5);
    send(4, 32'h1200, 32'h0100); check("bnd_sq_eq", last_raw, 1);
    send(4, 32'h1800, 32'h0400); check("bnd_tri_eq", last_raw, 3);
    send(4, 32'h17FF, 32'h0400); check("bnd_saw", last_raw, 4);
    send(4, 32'h11FF, 32'h3FFF); check("bnd_sq_lt", last_raw, 2);

    // majority and tie on ch0
    for (int i = 0; i < 4; i++) send_cls(0, 2);
    for (int i = 0; i < 4; i++) send_cls(0, 1);
`ifdef AI_RECOG_HYST_EN
    check("tie_type", last_type, 2);
`else
    check("tie_type", last_type, 1);
`endif
    check("tie_conf", last_conf, 128);
    send_cls(0, 1);
    check("maj_type", last_type, 1);
    check("maj_conf", last_conf, 160);

    // backpressure with a continuous stream on ch1
    fork
      stream(1, 12);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", int'(in_ready), 0);
        check("bp_out_valid_held", int'(out_valid), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain_check();
    check("ch1_full_warm", last_warm, 0);

    // per-channel clear
    @(posedge clk); #1 ch_clear = NUM_CH'(2);
    @(posedge clk); #1 ch_clear = '0;
    send_cls(1, 1);
    check("clr_conf", last_conf, 32);
    check("clr_warm", last_warm, 1);

    // invalid channel leaves history untouched
    send_cls(5, 1);
    check("inv_type", last_type, 0);
    check("inv_conf", last_conf, 0);
    check("inv_warm", last_warm, 1);
    check("inv_ch", last_ch, 5);
    send_cls(0, 1);
    check("inv_nochange_conf", last_conf, 192);

    // ai_enable low clears all history
    @(posedge clk); #1 ai_enable = 1'b0;
    @(negedge clk);
    check("dis_in_ready", int'(in_ready), 0);
    @(posedge clk); #1 ai_enable = 1'b1;
    send_cls(0, 1);
    check("en_conf", last_conf, 32);
    check("en_warm", last_warm, 1);

    // hysteresis scenario on ch3: 5 sine, 3 square, then 2 more square
    for (int i = 0; i < 5; i++) send_cls(3, 1);
    for (int i = 0; i < 3; i++) send_cls(3, 2);
    check("hy_base_type", last_type, 1);
    check("hy_base_conf", last_conf, 160);
    send_cls(3, 2);
`ifdef AI_RECOG_HYST_EN
    check("hy_hold_type", last_type, 1);
`else
    check("hy_hold_type", last_type, 2);
`endif
    check("hy_hold_conf", last_conf, 128);
    send_cls(3, 2);
    check("hy_switch_type", last_type, 2);
    check("hy_switch_conf", last_conf, 160);

    drain_check();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
